// File: rtl/tron_trail_map_pkg.sv
// Shared definitions for the TRON trail map: FSM state encoding, empty-cell
// value, and the width derivations used by the top and the cell RAM.
// Latency: n/a (declarations only). Backpressure: n/a.
package tron_trail_map_pkg;

  // Owner ID stored in a cell nobody has driven over yet.
  localparam int CELL_EMPTY = 0;

  typedef enum logic [2:0] {
    ST_CLEAR = 3'd0,
    ST_IDLE  = 3'd1,
    ST_RD    = 3'd2,
    ST_CHK   = 3'd3,
    ST_WR    = 3'd4,
    ST_DONE  = 3'd5
  } state_e;

  // Ceiling log2; clog2(1) = 0.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  // Owner ID width: values 0 (empty) .. num_players.
  function automatic int id_width(input int num_players);
    return clog2(num_players + 1);
  endfunction

  // Address width for a RAM of the given depth, never narrower than 1 bit.
  function automatic int addr_width(input int depth);
    return (depth > 1) ? clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/tron_trail_map_cell_ram.sv
// Single-port cell RAM holding the owner ID of every playfield cell.
// Latency: 1-cycle synchronous read; a read during a write returns the old data.
// Backpressure: none, accepts an access every cycle.
// Ports: clk, we (write enable), addr, wdata, rdata (registered read data).
module tron_cell_ram
  import tron_trail_map_pkg::*;
#(
  parameter int DEPTH  = 128,
  parameter int DATA_W = 2,
  localparam int AW    = addr_width(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // No reset on the array: the owning block wipes it explicitly after reset.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end

endmodule

// File: rtl/tron_trail_map.sv
// N-player TRON trail map: per tick checks every alive head against walls,
// trails and other heads, records losers, then writes survivors into the map.
// Latency: step_done 3*NUM_PLAYERS+1 cycles after accept; map wipe GRID_W*GRID_H cycles.
// Backpressure: step_ready only in IDLE; clear_req honoured only in IDLE.
// Ports: clk, resetn (async, active low), clear_req/clear_busy (round wipe),
//   step_valid/step_ready (head-position handshake), pos_x/pos_y (packed heads,
//   player k at [k*W +: W]), step_done (result pulse), lost (sticky flags),
//   game_over, winner (survivor index+1, 0 = draw/none).
// Optional: define TRON_BORDER_WALL_EN to make the outermost ring of cells lethal.
module tron_trail_map
  import tron_trail_map_pkg::*;
#(
  parameter int NUM_PLAYERS = 2,
  parameter int X_W         = 8,
  parameter int Y_W         = 7,
  parameter int GRID_W      = 160,
  parameter int GRID_H      = 120,
  localparam int ID_W       = id_width(NUM_PLAYERS)
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       clear_req,
  output logic                       clear_busy,
  input  logic                       step_valid,
  output logic                       step_ready,
  input  logic [NUM_PLAYERS*X_W-1:0] pos_x,
  input  logic [NUM_PLAYERS*Y_W-1:0] pos_y,
  output logic                       step_done,
  output logic [NUM_PLAYERS-1:0]     lost,
  output logic                       game_over,
  output logic [ID_W-1:0]            winner
);

  localparam int DEPTH  = GRID_W * GRID_H;
  localparam int AW     = addr_width(DEPTH);
  localparam int PIDX_W = clog2(NUM_PLAYERS);

  state_e state_q, state_d;

  logic [AW-1:0]          clr_cnt_q;
  logic [PIDX_W-1:0]      ply_q;
  logic [X_W-1:0]         px_q [NUM_PLAYERS];
  logic [Y_W-1:0]         py_q [NUM_PLAYERS];
  logic [NUM_PLAYERS-1:0] newloss_q, lost_q;
  logic                   game_over_q, step_done_q;
  logic [ID_W-1:0]        winner_q;

  logic [X_W-1:0]         cur_x;
  logic [Y_W-1:0]         cur_y;
  logic                   cur_alive, last_ply, in_range, on_wall, bad_pos;
  logic [AW-1:0]          cell_addr;
  logic [NUM_PLAYERS-1:0] headon, newloss_chk, lost_nx;
  logic [ID_W-1:0]        winner_nx;
  logic                   game_over_nx;
  int                     n_alive;

  logic                   ram_we;
  logic [AW-1:0]          ram_addr;
  logic [ID_W-1:0]        ram_wdata, ram_rdata;

  // Player currently being sequenced through RD/CHK or WR.
  assign cur_x     = px_q[ply_q];
  assign cur_y     = py_q[ply_q];
  assign cur_alive = ~lost_q[ply_q];
  assign last_ply  = (ply_q == PIDX_W'(NUM_PLAYERS - 1));
  assign in_range  = (32'(cur_x) < GRID_W) && (32'(cur_y) < GRID_H);
  // Only meaningful when in range; the product then always fits in AW bits.
  assign cell_addr = AW'(cur_y) * AW'(GRID_W) + AW'(cur_x);

`ifdef TRON_BORDER_WALL_EN
  assign on_wall = (cur_x == '0) || (32'(cur_x) == GRID_W - 1) ||
                   (cur_y == '0) || (32'(cur_y) == GRID_H - 1);
`else
  assign on_wall = 1'b0;
`endif

  // Positions that lose without consulting the map; their RAM read is skipped.
  assign bad_pos = ~in_range | on_wall;

  // Head-on: players alive at step start that land on the same cell all lose.
  always_comb begin
    headon = '0;
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      for (int j = 0; j < NUM_PLAYERS; j++) begin
        if (i != j && !lost_q[i] && !lost_q[j] &&
            px_q[i] == px_q[j] && py_q[i] == py_q[j]) begin
          headon[i] = 1'b1;
        end
      end
    end
  end

  // Loss set after the current CHK cycle; head-on folded in on the last player.
  always_comb begin
    newloss_chk = newloss_q;
    if (cur_alive && (bad_pos || ram_rdata != ID_W'(CELL_EMPTY))) begin
      newloss_chk[ply_q] = 1'b1;
    end
    if (last_ply) newloss_chk = newloss_chk | headon;
  end

  // Round outcome as it will stand once this step's losses are committed.
  always_comb begin
    lost_nx   = lost_q | newloss_q;
    n_alive   = 0;
    winner_nx = '0;
    for (int k = 0; k < NUM_PLAYERS; k++) begin
      if (!lost_nx[k]) begin
        n_alive   = n_alive + 1;
        winner_nx = ID_W'(k + 1);
      end
    end
    if (n_alive != 1) winner_nx = '0;
    game_over_nx = (n_alive <= 1);
  end

  // FSM next state and RAM port control.
  always_comb begin
    state_d   = state_q;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    unique case (state_q)
      ST_CLEAR: begin
        ram_we   = 1'b1;
        ram_addr = clr_cnt_q;
        if (clr_cnt_q == AW'(DEPTH - 1)) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (clear_req)       state_d = ST_CLEAR;
        else if (step_valid) state_d = ST_RD;
      end
      ST_RD: begin
        ram_addr = bad_pos ? '0 : cell_addr;
        state_d  = ST_CHK;
      end
      ST_CHK: begin
        state_d = last_ply ? ST_WR : ST_RD;
      end
      ST_WR: begin
        if (cur_alive && !newloss_q[ply_q]) begin
          ram_we    = 1'b1;
          ram_addr  = cell_addr;
          ram_wdata = ID_W'(ply_q) + ID_W'(1);
        end
        if (last_ply) state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_CLEAR;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= ST_CLEAR;
    else         state_q <= state_d;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      clr_cnt_q   <= '0;
      ply_q       <= '0;
      newloss_q   <= '0;
      lost_q      <= '0;
      game_over_q <= 1'b0;
      winner_q    <= '0;
      step_done_q <= 1'b0;
      for (int k = 0; k < NUM_PLAYERS; k++) begin
        px_q[k] <= '0;
        py_q[k] <= '0;
      end
    end else begin
      step_done_q <= 1'b0;
      unique case (state_q)
        ST_CLEAR: clr_cnt_q <= clr_cnt_q + AW'(1);
        ST_IDLE: begin
          if (clear_req) begin
            // New round: flags stay zero for the whole wipe.
            clr_cnt_q   <= '0;
            lost_q      <= '0;
            game_over_q <= 1'b0;
            winner_q    <= '0;
          end else if (step_valid) begin
            ply_q     <= '0;
            newloss_q <= '0;
            for (int k = 0; k < NUM_PLAYERS; k++) begin
              px_q[k] <= pos_x[k*X_W +: X_W];
              py_q[k] <= pos_y[k*Y_W +: Y_W];
            end
          end
        end
        ST_RD: ;
        ST_CHK: begin
          newloss_q <= newloss_chk;
          ply_q     <= last_ply ? '0 : ply_q + PIDX_W'(1);
        end
        ST_WR: ply_q <= last_ply ? '0 : ply_q + PIDX_W'(1);
        ST_DONE: begin
          lost_q      <= lost_nx;
          game_over_q <= game_over_nx;
          winner_q    <= winner_nx;
          step_done_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  tron_cell_ram #(
    .DEPTH (DEPTH),
    .DATA_W(ID_W)
  ) u_cell_ram (
    .clk  (clk),
    .we   (ram_we),
    .addr (ram_addr),
    .wdata(ram_wdata),
    .rdata(ram_rdata)
  );

  assign clear_busy = (state_q == ST_CLEAR);
  assign step_ready = (state_q == ST_IDLE);
  assign step_done  = step_done_q;
  assign lost       = lost_q;
  assign game_over  = game_over_q;
  assign winner     = winner_q;

endmodule
